rx_buffer: RTL

//  Receive end of the router link driven by tx_logic: accepts items presented with
//  <dir>_ena from an upstream tx_logic and back-pressures it through <dir>_busy.

---
 rtl/rx_buffer.sv | 81 ++++++++
 1 files changed

// File: rtl/rx_buffer.sv
// Receive side of a router link: takes items from an upstream tx_logic and back-pressures it.
// Items are stored in a small first-word-fall-through FIFO that the local tx_logic pops.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module rx_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  localparam int W = `PAYLOAD_SIZE + `ADDR_SZ
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [W-1:0]  item_in,
  output logic          busy,
  output logic [W-1:0]  item_out,
  output logic          empty,
  input  logic          read,
  output logic          overflow,
  output logic          underflow,
  output logic [15:0]   rx_count
);

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  // Flags decode straight from the count register; upstream builds ena from busy.
  assign busy  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = ena & ~busy;
  assign pop   = read & ~empty;

  assign item_out = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= item_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rx_count  <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        rx_count <= rx_count + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ena && busy) begin
        overflow <= 1'b1;
      end
      if (read && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
